// File: rtl/fxp_enable_pkg.sv
// Shared definitions for the clock-enable rate monitor: state encoding and
// a saturating increment helper.
package fxp_enable_pkg;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  // Increment v, clamping at the largest value representable in w bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/enable_interval_counter.sv
// Phase counter for the rate monitor: counts en-cycles since the last accepted
// strobe and flags the first cycle on which the next strobe is overdue.
module enable_interval_counter
  import fxp_enable_pkg::*;
#(
  parameter int unsigned CntWidth       = 16,
  parameter int unsigned ExpectedFactor = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                strobe,
  output logic [CntWidth-1:0] phase,
  output logic [CntWidth-1:0] interval,
  output logic                late_evt,
  output logic                late_pending
);

  localparam logic [CntWidth-1:0] LateAt = CntWidth'(ExpectedFactor - 1);

  logic [CntWidth-1:0] phase_q, phase_d;
  logic                late_q, late_d;

  assign interval     = CntWidth'(sat_inc(32'(phase_q), CntWidth));
  // Fires once per interval, on the en-cycle where the strobe should have come.
  assign late_evt     = en & ~strobe & (phase_q == LateAt) & ~late_q;
  assign late_pending = late_q;
  assign phase        = phase_q;

  always_comb begin
    phase_d = phase_q;
    late_d  = late_q;
    if (en) begin
      if (strobe) begin
        phase_d = '0;
        late_d  = 1'b0;
      end else begin
        phase_d = interval;
        if (late_evt) late_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      late_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      late_q  <= late_d;
    end
  end

endmodule

// File: rtl/enable_rate_monitor.sv
// Clock-enable rate monitor: measures the ce_in strobe period in en-cycles and
// locks after repeated matches. ENABLE_MONITOR_ERRCNT_EN adds err_count.
module enable_rate_monitor
  import fxp_enable_pkg::*;
#(
  parameter int unsigned ExpectedFactor = 2,
  parameter int unsigned LockCount      = 4,
  parameter int unsigned CntWidth       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                ce_in,
  output logic                locked,
  output logic [CntWidth-1:0] period,
  output logic                err_pulse,
  output logic [CntWidth-1:0] phase,
  output logic [1:0]          dbg_state
`ifdef ENABLE_MONITOR_ERRCNT_EN
  ,
  output logic [15:0]         err_count
`endif
);

  localparam int unsigned         MW      = $clog2(LockCount + 1);
  localparam logic [MW-1:0]       LockW   = MW'(LockCount);
  localparam logic [CntWidth-1:0] ExpectW = CntWidth'(ExpectedFactor);

  logic                strobe;
  logic [CntWidth-1:0] interval;
  logic                late_evt;
  logic                late_pending;

  mon_state_e          state_q, state_d;
  logic [MW-1:0]       mcnt_q, mcnt_d;
  logic [CntWidth-1:0] period_q, period_d;
  logic                err_q, err_d;
  logic                locked_q, locked_d;
  logic                match;

  assign strobe = en & ce_in;
  assign match  = (interval == ExpectW);

  enable_interval_counter #(
    .CntWidth       (CntWidth),
    .ExpectedFactor (ExpectedFactor)
  ) u_interval (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .strobe       (strobe),
    .phase        (phase),
    .interval     (interval),
    .late_evt     (late_evt),
    .late_pending (late_pending)
  );

  always_comb begin
    state_d  = state_q;
    mcnt_d   = mcnt_q;
    period_d = period_q;
    err_d    = 1'b0;
    if (strobe) begin
      case (state_q)
        SEEK: state_d = ACQUIRE;
        ACQUIRE: begin
          period_d = interval;
          if (match) begin
            mcnt_d = mcnt_q + MW'(1);
            if (mcnt_d == LockW) state_d = LOCKED;
          end else begin
            mcnt_d = '0;
            // A late interval was already reported when it went overdue.
            err_d  = ~late_pending;
          end
        end
        LOCKED: begin
          period_d = interval;
          if (!match) begin
            mcnt_d  = '0;
            err_d   = ~late_pending;
            state_d = ACQUIRE;
          end
        end
        default: state_d = SEEK;
      endcase
    end else if (late_evt && state_q != SEEK) begin
      err_d  = 1'b1;
      mcnt_d = '0;
      if (state_q == LOCKED) state_d = ACQUIRE;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SEEK;
      mcnt_q   <= '0;
      period_q <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      period_q <= period_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign period    = period_q;
  assign err_pulse = err_q;
  assign dbg_state = state_q;

`ifdef ENABLE_MONITOR_ERRCNT_EN
  logic [15:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (err_d) errcnt_d = 16'(sat_inc({16'd0, errcnt_q}, 16));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) errcnt_q <= '0;
    else      errcnt_q <= errcnt_d;
  end

  assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_enable_rate_monitor.sv
// Bench for enable_rate_monitor: two instances (factor 2 and factor 1) driven
// per cycle; a reference model queues expected outputs for per-DUT monitors.
module tb_enable_rate_monitor;

  localparam int W      = 52;
  localparam int MAXCNT = 65535;
  localparam int LC     = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en0 = 1'b0, ce0 = 1'b0, en1 = 1'b0, ce1 = 1'b0;

  logic        locked0, err0, locked1, err1;
  logic [15:0] period0, phase0, period1, phase1;
  logic [1:0]  st0, st1;
  logic [15:0] errc0_v, errc1_v;

`ifdef ENABLE_MONITOR_ERRCNT_EN
  logic [15:0] errc0, errc1;
  assign errc0_v = errc0;
  assign errc1_v = errc1;
`else
  assign errc0_v = 16'd0;
  assign errc1_v = 16'd0;
`endif

  enable_rate_monitor #(.ExpectedFactor(2), .LockCount(LC), .CntWidth(16)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .ce_in(ce0),
    .locked(locked0), .period(period0), .err_pulse(err0), .phase(phase0),
    .dbg_state(st0)
`ifdef ENABLE_MONITOR_ERRCNT_EN
    , .err_count(errc0)
`endif
  );

  enable_rate_monitor #(.ExpectedFactor(1), .LockCount(LC), .CntWidth(16)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .ce_in(ce1),
    .locked(locked1), .period(period1), .err_pulse(err1), .phase(phase1),
    .dbg_state(st1)
`ifdef ENABLE_MONITOR_ERRCNT_EN
    , .err_count(errc1)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // reference model state, one slot per instance
  int ef[2] = '{2, 1};
  int m_phase[2], m_period[2], m_run[2], m_errcnt[2];
  bit m_seen[2], m_locked[2], m_late[2];

  function automatic logic [W-1:0] pack(logic [1:0] st, logic lk, logic er,
                                        logic [15:0] pe, logic [15:0] ph, logic [15:0] ec);
    return {st, lk, er, pe, ph, ec};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_period[i] = 0; m_run[i] = 0; m_errcnt[i] = 0;
      m_seen[i] = 0; m_locked[i] = 0; m_late[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit e, input bit c, output logic [W-1:0] v);
    bit err;
    int iv;
    logic [1:0] st;
    logic [15:0] ec;
    err = 0;
    if (e) begin
      if (c) begin
        iv = (m_phase[i] + 1 > MAXCNT) ? MAXCNT : m_phase[i] + 1;
        if (!m_seen[i]) begin
          m_seen[i] = 1;
        end else begin
          m_period[i] = iv;
          if (iv == ef[i] && !m_late[i]) begin
            if (!m_locked[i]) begin
              m_run[i]++;
              if (m_run[i] >= LC) m_locked[i] = 1;
            end
          end else begin
            if (!m_late[i]) err = 1;
            m_run[i] = 0;
            m_locked[i] = 0;
          end
        end
        m_phase[i] = 0;
        m_late[i]  = 0;
      end else begin
        if (m_phase[i] == ef[i] - 1 && !m_late[i]) begin
          m_late[i] = 1;
          if (m_seen[i]) begin
            err = 1; m_run[i] = 0; m_locked[i] = 0;
          end
        end
        m_phase[i] = (m_phase[i] + 1 > MAXCNT) ? MAXCNT : m_phase[i] + 1;
      end
    end
    if (err && m_errcnt[i] < 65535) m_errcnt[i]++;
    st = !m_seen[i] ? 2'd0 : (m_locked[i] ? 2'd2 : 2'd1);
`ifdef ENABLE_MONITOR_ERRCNT_EN
    ec = 16'(m_errcnt[i]);
`else
    ec = 16'd0;
`endif
    v = pack(st, m_locked[i], err, 16'(m_period[i]), 16'(m_phase[i]), ec);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // driver tasks
  task automatic cycle(input bit e0, input bit c0, input bit e1, input bit c1);
    logic [W-1:0] v;
    @(negedge clk);
    en0 = e0; ce0 = c0; en1 = e1; ce1 = c1;
    model_step(0, e0, c0, v); exp_q0.push_back(v);
    model_step(1, e1, c1, v); exp_q1.push_back(v);
  endtask

  // n-1 quiet en-cycles then a strobe on dut0: interval n
  task automatic interval0(input int n);
    for (int k = 0; k < n - 1; k++) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_dut0"}, pack(st0, locked0, err0, period0, phase0, errc0_v), '0);
    check({name, "_dut1"}, pack(st1, locked1, err1, period1, phase1, errc1_v), '0);
  endtask

  // scoreboard monitors
  initial begin : mon0
    logic [W-1:0] e;
    forever begin
      @(posedge clk); #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check("dut0_cycle", pack(st0, locked0, err0, period0, phase0, errc0_v), e);
      end
    end
  end

  initial begin : mon1
    logic [W-1:0] e;
    forever begin
      @(posedge clk); #1;
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check("dut1_cycle", pack(st1, locked1, err1, period1, phase1, errc1_v), e);
      end
    end
  end

  initial begin : stim
    int gap;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b1;
    cycle(0, 0, 0, 0);

    // steady ce every 2nd en-cycle: lock on the 5th strobe
    for (int s = 0; s < 8; s++) interval0(2);

    // one overdue interval while locked, then relock
    interval0(3);
    for (int s = 0; s < 5; s++) interval0(2);

    // early strobe while locked
    interval0(1);
    for (int s = 0; s < 5; s++) interval0(2);

    // en toggling; ce during en=0 must be ignored
    for (int s = 0; s < 8; s++) begin
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(0, $urandom_range(0, 1), 0, 0);
    end

    // randomized intervals and enable gaps on both instances
    for (int s = 0; s < 80; s++) begin
      gap = ($urandom_range(0, 9) < 6) ? 2 : $urandom_range(1, 4);
      for (int k = 0; k < gap; k++) begin
        while ($urandom_range(0, 3) == 0)
          cycle(0, $urandom_range(0, 1), 0, $urandom_range(0, 1));
        cycle(1, (k == gap - 1), $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
      end
    end

    // asynchronous reset mid-interval while locked
    for (int s = 0; s < 6; s++) interval0(2);
    cycle(1, 0, 1, 1);
    @(negedge clk);
    en0 = 0; ce0 = 0; en1 = 0; ce1 = 0;
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // dut0: first strobe after reset is not compared; dut1: ce = en constant
    for (int s = 0; s < 8; s++) begin
      cycle(1, 0, 1, 1);
      cycle(1, 1, 1, 1);
    end
    cycle(1, 0, 1, 0);
    for (int s = 0; s < 7; s++) cycle(1, 0, 1, 1);
    cycle(0, 0, 0, 0);

    @(posedge clk); #3;
    n_chk++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d expected=0", exp_q0.size() + exp_q1.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
